wb_result_sequencer: RTL and testbench
======================================

Name: wb_result_sequencer

Overview:
- Stage directly downstream of execute; consumes one execute result bundle per instruction (up to four results with per-result writeback and destination-class flags).
- Serialises that bundle's register and segment results onto the single register-file write port, one result per cycle, in index order res1, res2, res3, res4.
- Commits eflags, pulses retire with PTCID when an instruction finishes, and back-pressures execute through in_stall.
- Memory-class results are not written here; the memory writeback path consumes them.

Parameters:
- NUM_RES, 4, result slots per bundle.
- DATA_W, 64, result data width.
- ID_W, 3, register/segment index width, taken from dest[ID_W-1:0].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute bundle valid (execute valid_out)
- in_eip  in  32  EIP of the instruction
- in_ptcid  in  7  PTC id
- in_eflags  in  18  eflags produced by execute
- in_size  in  2  result size (ressize)
- in_res  in  NUM_RES*DATA_W  res1..res4, res1 in the low slice
- in_dest  in  NUM_RES*32  res1_dest..res4_dest
- in_wb  in  NUM_RES  resN_wb
- in_is_reg  in  NUM_RES  resN_is_reg
- in_is_seg  in  NUM_RES  resN_is_seg
- flush  in  1  pipeline flush (branch mispredict or exception)
- rf_stall  in  1  register file cannot accept a write this cycle
- in_stall  out  1  execute must hold its bundle
- rf_we  out  1  register write strobe
- rf_is_seg  out  1  write targets the segment file
- rf_id  out  ID_W  register index
- rf_data  out  DATA_W  write data
- rf_size  out  2  write size
- flags_we  out  1  eflags commit strobe
- flags_out  out  18  committed eflags value
- retire  out  1  instruction-complete pulse
- retire_ptcid  out  7  PTCID of the retiring instruction
- retire_eip  out  32  EIP of the retiring instruction

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, pending=0, all holding registers 0. All outputs are 0, including in_stall.
- Holding register: one bundle. pending[i] = in_wb[i] & (in_is_reg[i] | in_is_seg[i]), captured on accept.
- States:
  - IDLE: nothing held.
  - DRAIN: bundle held; pending may be 0.
- in_ready = IDLE, or (DRAIN & done_now & ~rf_stall).
  - done_now: pending has at most one bit set.
  - in_stall = ~in_ready, combinational.
- Accept when in_valid & in_ready & ~flush. Capture the bundle into the holding registers; state becomes DRAIN at the next edge.
- DRAIN, each cycle with ~rf_stall:
  - sel = lowest set bit of pending.
  - If pending!=0: rf_we=1, with rf_id, rf_data, rf_is_seg and rf_size taken from slot sel. Clear pending[sel] at the edge.
  - When pending==0, or exactly one bit is set: retire=1, flags_we=1, flags_out=held eflags, retire_ptcid and retire_eip from the held bundle.
  - On that retire cycle, state becomes IDLE at the edge, or stays in DRAIN if a new bundle is accepted in the same cycle (back-to-back).
- rf_stall=1: rf_we, retire and flags_we forced to 0; all state held.
- Write-port outputs are combinational from the held registers; nothing is driven in IDLE.
- Latency:
  - Bundle accepted at edge N; first write in cycle N..N+1.
  - A bundle with k pending results retires in its k-th drain cycle (k>=1), or in its first drain cycle if k=0.
  - Sustained throughput: one write per cycle.
- Flush: highest priority. At the next edge pending=0 and state=IDLE, and no bundle is accepted that cycle. During the flush cycle, rf_we, retire and flags_we are forced to 0.
- Duplicate destinations in one bundle: written in index order, so the higher index wins.
- Results with is_mem set and neither is_reg nor is_seg set are never written here.
- Reset asserted mid-drain: remaining pending writes are discarded; no retire is issued.

Decomposition:
- Shared package: NUM_RES, DATA_W, ID_W, the IDLE/DRAIN state encodings, and the eflags width (18).
- One sub-module: wb_prio_pick4. Combinational lowest-set-bit selector returning the one-hot select, binary index, and a "one-or-none-left" flag. It drives the data mux and done_now.

Test Plan:
- Single result: in_wb=0001, is_reg=0001, dest1=3, res1=0x1234. Expect rf_we for one cycle with rf_id=3 and rf_data=0x1234. Expect retire in the same cycle, then IDLE.
- XCHG-style bundle: wb=0011, both is_reg, dest1=1, dest2=2. Expect a write to id1 then id2 on consecutive cycles. in_stall=1 in the first drain cycle; retire with the second write.
- Back-to-back: a second bundle is valid while the first bundle's last write occurs. Expect it accepted that cycle and its first write on the next cycle, with no bubble.
- Zero-write bundle (compare; wb=0000). Expect retire with flags_we=1, flags_out equal to in_eflags, and no rf_we.
- Mixed classes: wb=1111, is_reg=0101, is_seg=1000, is_mem=0010. Expect three writes (res1, res3, then res4 with rf_is_seg=1); res2 is skipped. rf_stall asserted for 2 cycles mid-drain freezes outputs and state.
- Flush in the second drain cycle of a 3-write bundle: no further rf_we, no retire, state=IDLE. A reset pulse during a drain gives the same result with all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_result_sequencer_pkg.sv
// Shared widths, state codes and holding-register
// layout for the writeback result sequencer.
package wb_result_sequencer_pkg;

  localparam int NUM_RES = 4;
  localparam int DATA_W  = 64;
  localparam int ID_W    = 3;
  localparam int FLAGS_W = 18;
  localparam int PTCID_W = 7;
  localparam int EIP_W   = 32;
  localparam int DEST_W  = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic [EIP_W-1:0]                   eip;
    logic [PTCID_W-1:0]                 ptcid;
    logic [FLAGS_W-1:0]                 eflags;
    logic [1:0]                         size;
    logic [NUM_RES-1:0][DATA_W-1:0]     res;
    logic [NUM_RES-1:0][ID_W-1:0]       id;
    logic [NUM_RES-1:0]                 seg;
  } hold_t;

endpackage

// File: rtl/wb_result_sequencer_if.sv
// Execute-to-writeback bundle handshake:
// bundle fields flow down, in_stall flows back.
interface wb_result_sequencer_if;
  import wb_result_sequencer_pkg::*;

  logic                      in_valid;
  logic [EIP_W-1:0]          in_eip;
  logic [PTCID_W-1:0]        in_ptcid;
  logic [FLAGS_W-1:0]        in_eflags;
  logic [1:0]                in_size;
  logic [NUM_RES*DATA_W-1:0] in_res;
  logic [NUM_RES*DEST_W-1:0] in_dest;
  logic [NUM_RES-1:0]        in_wb;
  logic [NUM_RES-1:0]        in_is_reg;
  logic [NUM_RES-1:0]        in_is_seg;
  logic                      in_stall;

  modport master (
    output in_valid, in_eip, in_ptcid,
    output in_eflags, in_size, in_res,
    output in_dest, in_wb, in_is_reg,
    output in_is_seg,
    input  in_stall
  );

  modport slave (
    input  in_valid, in_eip, in_ptcid,
    input  in_eflags, in_size, in_res,
    input  in_dest, in_wb, in_is_reg,
    input  in_is_seg,
    output in_stall
  );

endinterface

// File: rtl/wb_result_sequencer_prio_pick4.sv
// Lowest-set-bit picker over four pending slots;
// last flags that at most one slot remains.
module wb_prio_pick4 (
  input  logic [3:0] req,
  output logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       last
);

  // isolate lowest set bit and encode it
  always_comb begin
    onehot = req & (~req + 4'd1);
    last   = ((req & (req - 4'd1)) == 4'd0);
    idx    = 2'd0;
    unique case (1'b1)
      onehot[0]: idx = 2'd0;
      onehot[1]: idx = 2'd1;
      onehot[2]: idx = 2'd2;
      onehot[3]: idx = 2'd3;
      default:   idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/wb_result_sequencer.sv
// Serialises one execute bundle onto the single
// register-file write port, then retires it.
module wb_result_sequencer
  import wb_result_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  wb_result_sequencer_if.slave ex,
  input  logic                 flush,
  input  logic                 rf_stall,
  output logic                 rf_we,
  output logic                 rf_is_seg,
  output logic [ID_W-1:0]      rf_id,
  output logic [DATA_W-1:0]    rf_data,
  output logic [1:0]           rf_size,
  output logic                 flags_we,
  output logic [FLAGS_W-1:0]   flags_out,
  output logic                 retire,
  output logic [PTCID_W-1:0]   retire_ptcid,
  output logic [EIP_W-1:0]     retire_eip
);

  logic [0:0]         state_q, state_d;
  logic [NUM_RES-1:0] pending_q, pending_d;
  hold_t              hold_q, hold_d;

  logic [3:0] sel_oh;
  logic [1:0] sel_idx;
  logic       done_now;
  logic       drain, idle, go;
  logic       in_ready, accept;
  logic       unused_dest;

  wb_prio_pick4 u_pick (
    .req    (pending_q),
    .onehot (sel_oh),
    .idx    (sel_idx),
    .last   (done_now)
  );

  // only the low ID_W bits of each dest are an index
  assign unused_dest = ^ex.in_dest;

  // handshake, strobes and write-port data
  always_comb begin
    idle     = (state_q == ST_IDLE);
    drain    = (state_q == ST_DRAIN);
    go       = drain & ~rf_stall & ~flush;
    in_ready = idle | (drain & done_now & ~rf_stall);
    accept   = ex.in_valid & in_ready & ~flush;
    ex.in_stall = ~in_ready;

    rf_we     = go & (|pending_q);
    rf_is_seg = rf_we & hold_q.seg[sel_idx];
    rf_id     = rf_we ? hold_q.id[sel_idx] : '0;
    rf_data   = rf_we ? hold_q.res[sel_idx] : '0;
    rf_size   = rf_we ? hold_q.size : '0;

    retire       = go & done_now;
    flags_we     = retire;
    flags_out    = retire ? hold_q.eflags : '0;
    retire_ptcid = retire ? hold_q.ptcid : '0;
    retire_eip   = retire ? hold_q.eip : '0;
  end

  // next state: flush, then drain step, then accept
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      if (rf_we) pending_d = pending_q & ~sel_oh;
      if (retire) state_d = ST_IDLE;
      if (accept) begin
        state_d   = ST_DRAIN;
        pending_d = ex.in_wb
                  & (ex.in_is_reg | ex.in_is_seg);
        hold_d.eip    = ex.in_eip;
        hold_d.ptcid  = ex.in_ptcid;
        hold_d.eflags = ex.in_eflags;
        hold_d.size   = ex.in_size;
        hold_d.seg    = ex.in_is_seg;
        for (int i = 0; i < NUM_RES; i++) begin
          hold_d.res[i] =
            ex.in_res[i*DATA_W +: DATA_W];
          hold_d.id[i] =
            ex.in_dest[i*DEST_W +: ID_W];
        end
      end
    end
  end

  // state, pending mask and held bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_wb_result_sequencer.sv
// Randomised scoreboard bench for the writeback
// result sequencer with directed corner cases.
`timescale 1ns/1ps
module tb_wb_result_sequencer;
  import wb_result_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic rf_stall = 1'b0;
  logic rf_we, rf_is_seg;
  logic [ID_W-1:0] rf_id;
  logic [DATA_W-1:0] rf_data;
  logic [1:0] rf_size;
  logic flags_we, retire;
  logic [FLAGS_W-1:0] flags_out;
  logic [PTCID_W-1:0] retire_ptcid;
  logic [EIP_W-1:0] retire_eip;

  wb_result_sequencer_if ex ();

  wb_result_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .ex           (ex),
    .flush        (flush),
    .rf_stall     (rf_stall),
    .rf_we        (rf_we),
    .rf_is_seg    (rf_is_seg),
    .rf_id        (rf_id),
    .rf_data      (rf_data),
    .rf_size      (rf_size),
    .flags_we     (flags_we),
    .flags_out    (flags_out),
    .retire       (retire),
    .retire_ptcid (retire_ptcid),
    .retire_eip   (retire_eip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      eip;
    logic [6:0]       ptcid;
    logic [17:0]      fl;
    logic [1:0]       size;
    logic [3:0][63:0] res;
    logic [3:0][31:0] dest;
    logic [3:0]       wb;
    logic [3:0]       rg;
    logic [3:0]       sg;
  } bun_t;

  typedef struct {
    bit          ret;
    logic [2:0]  id;
    logic [63:0] data;
    bit          seg;
    logic [1:0]  size;
    logic [17:0] fl;
    logic [6:0]  ptcid;
    logic [31:0] eip;
  } exp_t;

  exp_t exp_q[$];
  bun_t src[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_rdy = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req);
    end
  endtask

  // reference: register/segment results in index
  // order, then one retire carrying the eflags
  function automatic void model_push(input bun_t b);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (b.wb[i] && (b.rg[i] || b.sg[i])) begin
        e = '{ret: 1'b0, id: b.dest[i][2:0],
              data: b.res[i], seg: b.sg[i],
              size: b.size, fl: '0, ptcid: '0,
              eip: '0};
        exp_q.push_back(e);
      end
    end
    e = '{ret: 1'b1, id: '0, data: '0, seg: 1'b0,
          size: '0, fl: b.fl, ptcid: b.ptcid,
          eip: b.eip};
    exp_q.push_back(e);
  endfunction

  // monitor: compare outputs mid-cycle, pop model
  always @(negedge clk) begin : mon
    int nw;
    nw = 0;
    if (!rst) begin
      m_rdy = 1'b0;
      chk("rst_we", {rf_we, rf_is_seg, flags_we,
                     retire, ex.in_stall}, 0);
      chk("rst_data", rf_data, 0);
      chk("rst_ret", {rf_id, rf_size, flags_out,
                      retire_ptcid, retire_eip}, 0);
    end else begin
      foreach (exp_q[i]) if (!exp_q[i].ret) nw++;
      m_rdy = (exp_q.size() == 0)
            || (nw <= 1 && !rf_stall);
      chk("in_stall", ex.in_stall, !m_rdy);
      if (flush || rf_stall || exp_q.size() == 0)
      begin
        chk("quiet_we", rf_we, 0);
        chk("quiet_ret", {retire, flags_we}, 0);
        if (flush) exp_q.delete();
      end else begin
        if (!exp_q[0].ret) begin
          chk("rf_we", rf_we, 1);
          chk("rf_id", rf_id, exp_q[0].id);
          chk("rf_data", rf_data, exp_q[0].data);
          chk("rf_is_seg", rf_is_seg, exp_q[0].seg);
          chk("rf_size", rf_size, exp_q[0].size);
          void'(exp_q.pop_front());
        end else begin
          chk("no_we", rf_we, 0);
        end
        if (exp_q.size() > 0 && exp_q[0].ret) begin
          chk("retire", {retire, flags_we}, 2'b11);
          chk("flags_out", flags_out, exp_q[0].fl);
          chk("ret_ptcid", retire_ptcid,
              exp_q[0].ptcid);
          chk("ret_eip", retire_eip, exp_q[0].eip);
          void'(exp_q.pop_front());
        end else begin
          chk("early_ret", retire, 0);
        end
      end
    end
  end

  task automatic apply(input bun_t b);
    ex.in_eip    = b.eip;
    ex.in_ptcid  = b.ptcid;
    ex.in_eflags = b.fl;
    ex.in_size   = b.size;
    ex.in_res    = b.res;
    ex.in_dest   = b.dest;
    ex.in_wb     = b.wb;
    ex.in_is_reg = b.rg;
    ex.in_is_seg = b.sg;
  endtask

  // one clock of stimulus; accept per model ready
  task automatic tick(input bit stl, input bit fl);
    @(posedge clk);
    #1;
    rf_stall = stl;
    flush = fl;
    if (src.size() > 0) begin
      ex.in_valid = 1'b1;
      apply(src[0]);
    end else begin
      ex.in_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    if (rst && ex.in_valid && m_rdy && !flush) begin
      model_push(src[0]);
      void'(src.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  function automatic bun_t mk(input logic [3:0] wb,
                              input logic [3:0] rg,
                              input logic [3:0] sg);
    bun_t b;
    b.eip   = $urandom;
    b.ptcid = 7'($urandom);
    b.fl    = 18'($urandom);
    b.size  = 2'($urandom);
    b.wb = wb;
    b.rg = rg;
    b.sg = sg;
    for (int i = 0; i < 4; i++) begin
      b.res[i]  = {$urandom, $urandom};
      b.dest[i] = $urandom;
    end
    return b;
  endfunction

  bun_t b;

  initial begin
    ex.in_valid = 1'b0;
    apply(mk(4'h0, 4'h0, 4'h0));
    idle(3);
    @(posedge clk);
    #1 rst = 1'b1;

    b = mk(4'b0001, 4'b0001, 4'b0000);
    b.dest[0] = 32'd3;
    b.res[0]  = 64'h1234;
    src.push_back(b);
    idle(4);

    b = mk(4'b0011, 4'b0011, 4'b0000);
    b.dest[0] = 32'd1;
    b.dest[1] = 32'd2;
    src.push_back(b);
    idle(5);

    src.push_back(mk(4'b0011, 4'b0011, 4'b0000));
    src.push_back(mk(4'b0101, 4'b0001, 4'b0100));
    src.push_back(mk(4'b0000, 4'b0000, 4'b0000));
    src.push_back(mk(4'b0001, 4'b0001, 4'b0000));
    idle(10);

    src.push_back(mk(4'b1111, 4'b0101, 4'b1000));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    idle(5);

    src.push_back(mk(4'b0111, 4'b0111, 4'b0000));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    idle(3);
    chk("flush_empty", exp_q.size(), 0);

    src.push_back(mk(4'b0111, 4'b0011, 4'b0100));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_we", {rf_we, retire, flags_we}, 0);
    chk("async_data", rf_data, 0);
    exp_q.delete();
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    for (int n = 0; n < 400; n++) begin
      if (src.size() < 2 && $urandom_range(0, 3) != 0)
        src.push_back(mk(4'($urandom),
                         4'($urandom),
                         4'($urandom)));
      tick($urandom_range(0, 4) == 0,
           $urandom_range(0, 24) == 0);
    end
    while (src.size() > 0) void'(src.pop_front());
    idle(12);
    chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
